tx_handshake_ctrl: RTL and testbench

Sequencer for the source→receiver transfer link driven by `validdata`/`acknowledge`. Captures a word on a one-cycle `validdata` pulse, holds a request to the receiver until `acknowledge`, and retries with backoff on timeout. It reports completion, failure and overrun as one-cycle pulses. Sits between the data source and the receiver interface; the existing stimulus generator (`clk`, `rst`, `validdata`, `acknowledge`) drives it directly.

---
 rtl/tx_hs_pkg.sv | 14 +
 rtl/hs_timer.sv | 23 ++
 rtl/tx_handshake_ctrl.sv | 103 ++++++++++
 tb/tb_tx_handshake_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tx_hs_pkg.sv
// tx_hs_pkg: shared state encoding and default parameters for the transfer handshake controller
package tx_hs_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_BACKOFF,
    ST_DONE,
    ST_FAIL
  } tx_hs_state_t;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_TIMEOUT   = 64;
  localparam int DEF_MAX_RETRY = 3;
  localparam int DEF_BACKOFF   = 2;
endpackage

// File: rtl/hs_timer.sv
// hs_timer: clearable up-counter that saturates at a loadable terminal value and flags it
module hs_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc = (cnt_q == last);
  // next count: clear wins, otherwise count up until the terminal value and hold there
  always_comb begin
    cnt_d = clr ? '0 : (en && !tc) ? cnt_q + 1'b1 : cnt_q;
  end
  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tx_handshake_ctrl.sv
// tx_handshake_ctrl: captures a source word, requests until acknowledged, retries with backoff on timeout
module tx_handshake_ctrl
  import tx_hs_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int BACKOFF   = DEF_BACKOFF,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validdata,
  input  logic [DATA_W-1:0] data_in,
  input  logic              acknowledge,
  output logic              req,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              overrun,
  output logic [RW-1:0]     retry_cnt
);
  localparam int TW = $clog2(TIMEOUT > BACKOFF ? TIMEOUT : BACKOFF);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] BO_LAST = TW'(BACKOFF - 1);
  localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRY);

  tx_hs_state_t      state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              req_q, req_d, busy_q, busy_d, done_q, done_d;
  logic              error_q, error_d, overrun_q, overrun_d;
  logic              tc;

  hs_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_d != state_q),
    .en   (state_q == ST_WAIT_ACK || state_q == ST_BACKOFF),
    .last (state_q == ST_BACKOFF ? BO_LAST : TO_LAST),
    .tc   (tc)
  );

  // next state, capture, retry count and registered outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_IDLE: if (validdata) begin
        state_d = ST_WAIT_ACK;
        data_d  = data_in;
        retry_d = '0;
      end
      ST_WAIT_ACK: if (acknowledge) state_d = ST_DONE;
        else if (tc) begin
          if (retry_q < MAX_R) begin
            state_d = ST_BACKOFF;
            retry_d = retry_q + 1'b1;
          end else state_d = ST_FAIL;
        end
      ST_BACKOFF: if (tc) state_d = ST_WAIT_ACK;
      default: state_d = ST_IDLE;
    endcase
    req_d     = (state_d == ST_WAIT_ACK);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    error_d   = (state_d == ST_FAIL);
    overrun_d = validdata && (state_q != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      retry_q   <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      retry_q   <= retry_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  assign req       = req_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign overrun   = overrun_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_tx_handshake_ctrl.sv
// tb_tx_handshake_ctrl: directed checks of capture, ack, timeout/retry, overrun, reset and ignored acks
module tb_tx_handshake_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       validdata = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       acknowledge = 1'b0;
  logic       req, busy, done, error, overrun;
  logic [7:0] data_out;
  logic [1:0] retry_cnt;
  int n_chk = 0, n_fail = 0;
  int req_n = 0, rise_n = 0, done_n = 0, error_n = 0, ovr_n = 0;
  logic req_prev = 1'b0;

  tx_handshake_ctrl dut (
    .clk(clk), .rst(rst), .validdata(validdata), .data_in(data_in),
    .acknowledge(acknowledge), .req(req), .data_out(data_out), .busy(busy),
    .done(done), .error(error), .overrun(overrun), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req) req_n++;
    if (req && !req_prev) rise_n++;
    req_prev = req;
    if (done) done_n++;
    if (error) error_n++;
    if (overrun) ovr_n++;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    req_n = 0; rise_n = 0; done_n = 0; error_n = 0; ovr_n = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [7:0] d);
    validdata = 1'b1; data_in = d;
    step();
    validdata = 1'b0;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step();
    chk("rst_req", req, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_error", error, 0); chk("rst_ovr", overrun, 0); chk("rst_retry", retry_cnt, 0);
    chk("rst_data", data_out, 0);

    // normal transfer, ack 45 cycles after capture
    clr_cnt();
    capture(8'hA5);
    chk("t1_req", req, 1); chk("t1_busy", busy, 1); chk("t1_data", data_out, 8'hA5);
    step(44);
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    chk("t1_req_low", req, 0); chk("t1_done", done, 1); chk("t1_busy_done", busy, 1);
    step();
    chk("t1_done_clr", done, 0); chk("t1_idle", busy, 0);
    chk("t1_req_cycles", req_n, 45); chk("t1_done_n", done_n, 1);
    chk("t1_retry", retry_cnt, 0); chk("t1_data_hold", data_out, 8'hA5);

    // no ack ever: 4 windows of 64 with 2-cycle gaps, then FAIL
    clr_cnt();
    capture(8'h11);
    step(64);
    chk("t2_backoff_req", req, 0); chk("t2_retry1", retry_cnt, 1);
    step(197);
    chk("t2_last_req", req, 1); chk("t2_retry3", retry_cnt, 3); chk("t2_no_err_yet", error, 0);
    step();
    chk("t2_error", error, 1); chk("t2_req_low", req, 0); chk("t2_busy_fail", busy, 1);
    step();
    chk("t2_error_clr", error, 0); chk("t2_idle", busy, 0);
    chk("t2_req_cycles", req_n, 256); chk("t2_windows", rise_n, 4);
    chk("t2_error_n", error_n, 1); chk("t2_done_n", done_n, 0);
    chk("t2_retry_hold", retry_cnt, 3); chk("t2_data", data_out, 8'h11);

    // ack coincides with the first timeout
    clr_cnt();
    capture(8'h5A);
    chk("t3_retry_clr", retry_cnt, 0);
    step(63);
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    chk("t3_done", done, 1); chk("t3_retry", retry_cnt, 0); chk("t3_req_low", req, 0);
    step();
    chk("t3_idle", busy, 0); chk("t3_req_cycles", req_n, 64); chk("t3_windows", rise_n, 1);
    chk("t3_error_n", error_n, 0);

    // overrun during WAIT_ACK and in the DONE cycle
    clr_cnt();
    capture(8'hA5);
    step();
    validdata = 1'b1; data_in = 8'h3C;
    step();
    validdata = 1'b0;
    chk("t4_ovr", overrun, 1); chk("t4_data", data_out, 8'hA5); chk("t4_req", req, 1);
    step();
    chk("t4_ovr_clr", overrun, 0);
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    chk("t4_done", done, 1);
    validdata = 1'b1; data_in = 8'h3C;
    step();
    validdata = 1'b0;
    chk("t4_b2b_ovr", overrun, 1); chk("t4_b2b_idle", busy, 0); chk("t4_b2b_data", data_out, 8'hA5);
    step(2);
    chk("t4_still_idle", busy, 0); chk("t4_ovr_n", ovr_n, 2); chk("t4_done_n", done_n, 1);

    // async reset mid-WAIT_ACK
    clr_cnt();
    capture(8'h77);
    step(5);
    #2 rst = 1'b1;
    #1;
    chk("t5_req_async", req, 0); chk("t5_busy_async", busy, 0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("t5_done_n", done_n, 0); chk("t5_error_n", error_n, 0); chk("t5_data_rst", data_out, 0);
    capture(8'h42);
    chk("t5_req", req, 1); chk("t5_data", data_out, 8'h42);
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    chk("t5_done", done, 1);
    step();

    // ack in IDLE and during BACKOFF is ignored
    clr_cnt();
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    chk("t6_idle_busy", busy, 0); chk("t6_idle_done", done, 0);
    capture(8'h99);
    step(64);
    chk("t6_in_backoff", req, 0); chk("t6_retry", retry_cnt, 1);
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    chk("t6_bo_done", done, 0); chk("t6_bo_req", req, 0); chk("t6_bo_busy", busy, 1);
    step();
    chk("t6_rewait", req, 1);
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    chk("t6_done", done, 1); chk("t6_retry_keep", retry_cnt, 1);
    step();
    chk("t6_done_n", done_n, 1); chk("t6_error_n", error_n, 0); chk("t6_ovr_n", ovr_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
